// File: rtl/four_way_arbiter.sv
// Round-robin four-requester arbiter with locked bursts, driving a 4:1 select
// and a single-entry valid/ready output register.
module four_way_arbiter #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned     BEAT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST);
  localparam bit              BURST_EN  = (MAX_BURST > 1);

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [1:0]          ptr;
  logic [1:0]          ptr_n;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   beat_n;
  logic                accept;
  logic                load;
  logic [1:0]          win;
  logic [1:0]          idx;
  logic [WIDTH-1:0]    load_data;

  // The slot can take a beat when it is empty or being drained this cycle.
  assign accept = ~out_valid | out_ready;

  // Winner selection and next-state; in BURST the owner is the last winner.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    beat_n  = beat;
    load    = 1'b0;
    win     = ptr;
    idx     = ptr;
    case (state)
      ARB: begin
        if (accept) begin
          for (int unsigned i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!load && req[idx]) begin
              load = 1'b1;
              win  = idx;
            end
          end
        end
        if (load) begin
          ptr_n  = win;
          beat_n = BEAT_W'(1);
          if (BURST_EN && lock[win]) begin
            state_n = BURST;
          end
        end
      end
      BURST: begin
        if (accept) begin
          if (req[ptr]) begin
            load   = 1'b1;
            beat_n = beat + BEAT_W'(1);
            if (beat_n == BEAT_LAST || !lock[ptr]) begin
              state_n = ARB;
            end
          end else begin
            state_n = ARB;
          end
        end
      end
      default: state_n = ARB;
    endcase
  end

  // Grant and select are combinational; grant is suppressed while in reset.
  always_comb begin
    gnt = 4'b0000;
    sel = ptr;
    if (reset_n && load) begin
      gnt[win] = 1'b1;
      sel      = win;
    end
  end

  always_comb begin
    load_data = in0;
    case (win)
      2'd0: load_data = in0;
      2'd1: load_data = in1;
      2'd2: load_data = in2;
      2'd3: load_data = in3;
      default: load_data = in0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      ptr       <= 2'b11;
      beat      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      beat      <= beat_n;
      busy      <= (state_n == BURST);
      out_valid <= load | (out_valid & ~out_ready);
      if (load) begin
        out_data <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_four_way_arbiter.sv
// Bench for four_way_arbiter: directed scenarios plus a randomized run, all
// checked against a cycle model built from the arbitration rules.
module tb_four_way_arbiter;

  localparam int unsigned WIDTH     = 64;
  localparam int unsigned MAX_BURST = 4;

  logic             clk;
  logic             reset_n;
  logic [3:0]       req;
  logic [3:0]       lock;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int n_vec;
  int n_err;

  // Reference model state
  int               m_ptr;
  bit               m_burst;
  int               m_beat;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  bit               m_accept;
  bit               m_load;
  int               m_idx;
  logic [3:0]       exp_gnt;
  logic [1:0]       exp_sel;

  four_way_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] pick(input int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 3; m_burst = 0; m_beat = 0; m_valid = 0; m_data = '0;
  endtask

  // Decision for the current cycle from the present inputs.
  task automatic model_comb();
    m_accept = !m_valid || out_ready;
    m_load   = 0;
    m_idx    = m_ptr;
    if (reset_n) begin
      if (!m_burst) begin
        if (m_accept) begin
          for (int k = 1; k <= 4; k++) begin
            int c = (m_ptr + k) % 4;
            if (!m_load && req[c]) begin
              m_load = 1;
              m_idx  = c;
            end
          end
        end
      end else if (m_accept && req[m_ptr]) begin
        m_load = 1;
        m_idx  = m_ptr;
      end
    end
    exp_gnt = m_load ? 4'(1 << m_idx) : 4'b0000;
    exp_sel = 2'(m_idx);
  endtask

  // State update at the clock edge, using the decision made before it.
  task automatic model_clock();
    if (m_load) begin
      m_data  = pick(m_idx);
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (!m_burst) begin
      if (m_load) begin
        m_ptr   = m_idx;
        m_beat  = 1;
        m_burst = lock[m_idx] && (MAX_BURST > 1);
      end
    end else if (m_accept) begin
      if (m_load) begin
        m_beat++;
        if (m_beat == MAX_BURST || !lock[m_ptr]) m_burst = 0;
      end else begin
        m_burst = 0;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'hF; lock = 4'h0; out_ready = 1'b1;
    in0 = 64'h1111; in1 = 64'h2222; in2 = 64'h3333; in3 = 64'h4444;
    model_reset();
    @(negedge clk);
    settle();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_vec++; if (sel !== 2'b11) begin n_err++; $display("FAIL reset_sel: got %b want 11", sel); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    req = 4'hF; lock = 4'h0; out_ready = 1'b1;
    in0 = {$urandom, $urandom}; in1 = {$urandom, $urandom};
    in2 = {$urandom, $urandom}; in3 = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      settle();
      n_vec++;
      if (gnt !== 4'(1 << (i % 4)) || gnt !== exp_gnt) begin
        n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, 4'(1 << (i % 4)));
      end
      n_vec++;
      if (sel !== 2'(i % 4)) begin n_err++; $display("FAIL rr_sel[%0d]: got %0d want %0d", i, sel, i % 4); end
      if (i > 0) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== pick(i - 1)) begin
          n_err++; $display("FAIL rr_data[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, pick(i - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] hold;
    hold = out_data;
    req = 4'b0101; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in0 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
      settle();
      n_vec++; if (gnt !== 4'b0000 || exp_gnt !== 4'b0000) begin n_err++; $display("FAIL bp_gnt[%0d]: got %b want 0000", i, gnt); end
      n_vec++; if (out_data !== hold || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, hold); end
      tick();
    end
    out_ready = 1'b1;
    settle();
    n_vec++; if (gnt !== 4'b0100 || gnt !== exp_gnt) begin n_err++; $display("FAIL bp_resume: got %b want 0100", gnt); end
    tick();
    req = 4'b0001;
    settle();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL bp_pending: got %b want 0001", gnt); end
    tick();
  endtask

  task automatic test_burst_full();
    req = 4'b0010; lock = 4'h0; out_ready = 1'b1;
    settle();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL bf_setup: got %b want 0010", gnt); end
    tick();
    req = 4'b0110; lock = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      in2 = {$urandom, $urandom};
      settle();
      n_vec++; if (gnt !== 4'b0100 || gnt !== exp_gnt) begin n_err++; $display("FAIL bf_gnt[%0d]: got %b want 0100", i, gnt); end
      n_vec++; if (busy !== (i > 0) || busy !== m_burst) begin n_err++; $display("FAIL bf_busy[%0d]: got %b want %b", i, busy, i > 0); end
      if (i > 0) begin
        n_vec++; if (out_data !== m_data) begin n_err++; $display("FAIL bf_data[%0d]: got %h want %h", i, out_data, m_data); end
      end
      tick();
    end
    settle();
    n_vec++; if (gnt !== 4'b0010 || gnt !== exp_gnt) begin n_err++; $display("FAIL bf_after: got %b want 0010", gnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bf_after_busy: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_burst_early();
    req = 4'b0100; lock = 4'b0100; out_ready = 1'b1;
    settle();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL be_lock_b1: got %b want 0100", gnt); end
    tick();
    lock = 4'b0000;
    settle();
    n_vec++; if (gnt !== 4'b0100 || busy !== 1'b1) begin n_err++; $display("FAIL be_lock_b2: got %b/%b want 0100/1", gnt, busy); end
    tick();
    req = 4'b0000;
    settle();
    n_vec++; if (gnt !== 4'b0000 || busy !== 1'b0 || busy !== m_burst) begin n_err++; $display("FAIL be_lock_end: got %b/%b want 0000/0", gnt, busy); end
    tick();
    req = 4'b0100; lock = 4'b0100;
    settle();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL be_drop_b1: got %b want 0100", gnt); end
    tick();
    settle();
    n_vec++; if (gnt !== 4'b0100 || busy !== 1'b1) begin n_err++; $display("FAIL be_drop_b2: got %b/%b want 0100/1", gnt, busy); end
    tick();
    req = 4'b0001;
    settle();
    n_vec++; if (gnt !== 4'b0000 || exp_gnt !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL be_drop_gap: got %b/%b want 0000/1", gnt, busy); end
    tick();
    settle();
    n_vec++; if (gnt !== 4'b0001 || busy !== 1'b0) begin n_err++; $display("FAIL be_drop_arb: got %b/%b want 0001/0", gnt, busy); end
    tick();
  endtask

  task automatic test_single();
    logic [2:0] rdy_pat;
    req = 4'b1000; lock = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in3 = {$urandom, $urandom};
      settle();
      n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL single_gnt[%0d]: got %b want 1000", i, gnt); end
      if (i > 0) begin
        n_vec++; if (out_valid !== 1'b1 || out_data !== m_data) begin n_err++; $display("FAIL single_data[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, m_data); end
      end
      tick();
    end
    rdy_pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      out_ready = rdy_pat[i];
      settle();
      n_vec++;
      if (gnt !== (rdy_pat[i] ? 4'b1000 : 4'b0000) || gnt !== exp_gnt) begin
        n_err++; $display("FAIL single_ready[%0d]: got %b want %b", i, gnt, rdy_pat[i] ? 4'b1000 : 4'b0000);
      end
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midburst();
    req = 4'b0100; lock = 4'b0100; out_ready = 1'b1;
    settle();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL rm_b1: got %b want 0100", gnt); end
    tick();
    settle();
    n_vec++; if (gnt !== 4'b0100 || busy !== 1'b1) begin n_err++; $display("FAIL rm_b2: got %b/%b want 0100/1", gnt, busy); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rm_gnt: got %b want 0000", gnt); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
    @(negedge clk);
    reset_n = 1'b1; req = 4'hF; lock = 4'h0;
    settle();
    n_vec++; if (gnt !== 4'b0001 || gnt !== exp_gnt) begin n_err++; $display("FAIL rm_first: got %b want 0001", gnt); end
    tick();
  endtask

  task automatic test_random();
    req = 4'h0;
    for (int n = 0; n < 400; n++) begin
      in0 = {$urandom, $urandom}; in1 = {$urandom, $urandom};
      in2 = {$urandom, $urandom}; in3 = {$urandom, $urandom};
      lock      = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      req       = req | (4'($urandom) & 4'($urandom));
      if (m_burst && $urandom_range(0, 5) == 0) req[m_ptr] = 1'b0;
      settle();
      n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, gnt, exp_gnt); end
      n_vec++; if (sel !== exp_sel) begin n_err++; $display("FAIL rnd_sel[%0d]: got %0d want %0d", n, sel, exp_sel); end
      n_vec++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, m_valid); end
      n_vec++; if (out_data !== m_data) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", n, out_data, m_data); end
      n_vec++; if (busy !== m_burst) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy, m_burst); end
      tick();
      req = req & ~exp_gnt;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; req = 4'h0; lock = 4'h0; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_burst_full();
    test_burst_early();
    test_single();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
